// File: rtl/spi_reg_slave.sv
// SPI mode-0 slave that turns 40-bit {cmd, data} frames into register-bank
// write strobes and read-address/readback shifts, all in the clk_clk domain.
//
// state  | meaning
// IDLE   | no frame; waiting for a synchronized SS_n falling edge
// CMD    | shifting in the 8 command bits
// DATA   | shifting 32 data bits in (write) or out on MISO (read)
// WAIT_SS| frame complete; extra SCLK edges ignored until SS_n rises
module spi_reg_slave #(
  parameter int NUM_REGS    = 60,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        spi_SCLK,
  input  logic        spi_MOSI,
  input  logic        spi_SS_n,
  output logic        spi_MISO,
  output logic        spi_MISO_oe,
  output logic        reg_wr_en,
  output logic [5:0]  reg_wr_addr,
  output logic [31:0] reg_wr_data,
  output logic [5:0]  reg_rd_addr,
  input  logic [31:0] reg_rd_data,
  output logic        frame_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_DATA = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  localparam logic [6:0] NUM_REGS_W = 7'(NUM_REGS);

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] ss_sync_q;
  logic [SYNC_STAGES:0]   warm_q;
  logic                   sclk_prev_q;
  logic                   ss_prev_q;

  logic sclk_s, mosi_s, ss_s, warm;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [31:0] rx_q, rx_d;
  logic [31:0] tx_q, tx_d;
  logic        miso_q, miso_d;
  logic        rd_load_q, rd_load_d;
  logic [5:0]  rd_addr_q, rd_addr_d;
  logic        wr_en_q, wr_en_d;
  logic [5:0]  wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        err_q, err_d;
  logic [7:0]  cmd_next;
  logic [31:0] data_next;

  function automatic logic addr_ok(input logic [5:0] a);
    return ({1'b0, a} < NUM_REGS_W);
  endfunction

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= '1;
      warm_q      <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q[0] <= spi_SCLK;
      mosi_sync_q[0] <= spi_MOSI;
      ss_sync_q[0]   <= spi_SS_n;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sclk_sync_q[i] <= sclk_sync_q[i-1];
        mosi_sync_q[i] <= mosi_sync_q[i-1];
        ss_sync_q[i]   <= ss_sync_q[i-1];
      end
      warm_q      <= {warm_q[SYNC_STAGES-1:0], 1'b1};
      sclk_prev_q <= sclk_s;
      ss_prev_q   <= ss_s;
    end
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];

  // Edges only count once both compared samples came from the pins, so a
  // reset released mid-frame cannot fake an SS_n falling edge.
  assign warm      = warm_q[SYNC_STAGES];
  assign sclk_rise = warm &  sclk_s & ~sclk_prev_q;
  assign sclk_fall = warm & ~sclk_s &  sclk_prev_q;
  assign ss_rise   = warm &  ss_s   & ~ss_prev_q;
  assign ss_fall   = warm & ~ss_s   &  ss_prev_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cmd_q     <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      miso_q    <= 1'b0;
      rd_load_q <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      miso_q    <= miso_d;
      rd_load_q <= rd_load_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    rd_load_d = 1'b0;
    rd_addr_d = rd_addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = 1'b0;
    cmd_next  = {cmd_q[6:0], mosi_s};
    data_next = {rx_q[30:0], mosi_s};

    // Read data is sampled the cycle after the address is presented.
    if (rd_load_q) begin
      tx_d = addr_ok(rd_addr_q) ? reg_rd_data : '0;
    end

    case (state_q)
      S_IDLE: begin
        miso_d = 1'b0;
        if (ss_fall) begin
          state_d = S_CMD;
          cnt_d   = '0;
          cmd_d   = '0;
          rx_d    = '0;
          tx_d    = '0;
        end
      end
      S_CMD: begin
        if (ss_rise) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          miso_d  = 1'b0;
        end else begin
          if (sclk_fall) begin
            miso_d = 1'b0;
          end
          if (sclk_rise) begin
            cmd_d = cmd_next;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd7) begin
              state_d = S_DATA;
              if (cmd_next[7]) begin
                rd_addr_d = cmd_next[5:0];
                rd_load_d = 1'b1;
              end
            end
          end
        end
      end
      S_DATA: begin
        if (ss_rise) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          miso_d  = 1'b0;
        end else begin
          if (sclk_fall) begin
            if (cmd_q[7]) begin
              miso_d = tx_q[31];
              tx_d   = {tx_q[30:0], 1'b0};
            end else begin
              miso_d = 1'b0;
            end
          end
          if (sclk_rise) begin
            rx_d  = data_next;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd39) begin
              state_d = S_WAIT;
              if (cmd_q[6]) begin
                err_d = 1'b1;
              end else if (!cmd_q[7]) begin
                if (addr_ok(cmd_q[5:0])) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = cmd_q[5:0];
                  wr_data_d = data_next;
                end else begin
                  err_d = 1'b1;
                end
              end
            end
          end
        end
      end
      S_WAIT: begin
        if (sclk_fall) begin
          miso_d = 1'b0;
        end
        if (ss_rise) begin
          state_d = S_IDLE;
          miso_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign spi_MISO    = miso_q;
  assign spi_MISO_oe = ~ss_s & ((state_q != S_IDLE) | ss_fall);
  assign reg_wr_en   = wr_en_q;
  assign reg_wr_addr = wr_addr_q;
  assign reg_wr_data = wr_data_q;
  assign reg_rd_addr = rd_addr_q;
  assign frame_err   = err_q;

endmodule

// File: doc/spi_reg_slave.md
SPI_REG_SLAVE -- requirements
Module: spi_reg_slave

Interface
REQ-001 Parameter NUM_REGS, default 60: number of implemented registers; addresses 0..NUM_REGS-1 are valid.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth on SCLK, MOSI and SS_n.
REQ-003 clk_clk  in  1: system clock; all logic is clocked on its rising edge.
REQ-004 reset_reset_n  in  1: asynchronous, active-low reset.
REQ-005 spi_SCLK  in  1: SPI clock from the master; mode 0 (CPOL=0, CPHA=0).
REQ-006 spi_MOSI  in  1: master-to-slave data, MSB first.
REQ-007 spi_SS_n  in  1: active-low frame select.
REQ-008 spi_MISO  out  1: slave-to-master data, MSB first.
REQ-009 spi_MISO_oe  out  1: high while spi_SS_n (synchronized) is low; board tristates MISO otherwise.
REQ-010 reg_wr_en  out  1: one-cycle write strobe.
REQ-011 reg_wr_addr  out  6: write address.
REQ-012 reg_wr_data  out  32: write data.
REQ-013 reg_rd_addr  out  6: read address presented to the register bank.
REQ-014 reg_rd_data  in  32: register bank read data; valid one clk_clk cycle after reg_rd_addr changes.
REQ-015 frame_err  out  1: one-cycle pulse on an aborted or invalid frame.

Function
REQ-016 SCLK, MOSI and SS_n shall pass through SYNC_STAGES flops; SCLK edges are detected from the last two synchronized samples; clk_clk is at least 8x SCLK.
REQ-017 Frame = 40 bits: cmd[7:0] then data[31:0]; cmd[7]=1 read, 0 write; cmd[6] reserved, must be 0; cmd[5:0] address.
REQ-018 MOSI shall be sampled on synchronized SCLK rising edges; MISO shall change only on synchronized SCLK falling edges.
REQ-019 States IDLE, CMD, DATA, WAIT_SS; IDLE->CMD on SS_n falling; CMD->DATA after 8th rising edge; DATA->WAIT_SS after 40th rising edge; any state->IDLE on SS_n rising.
REQ-020 A 6-bit bit counter shall count rising edges within a frame and clear on entry to CMD.
REQ-021 At the 8th rising edge of a read, reg_rd_addr shall load cmd[5:0]; one cycle later the 32-bit TX shift register shall load reg_rd_data, or 0 if the address is >= NUM_REGS.
REQ-022 MISO shall output TX bit 31 from the falling edge after the 8th rising edge, then shift once per falling edge; MISO is 0 during CMD, during WAIT_SS, and for write frames.
REQ-023 On the 40th rising edge of a write with address < NUM_REGS and cmd[6]=0, reg_wr_addr/reg_wr_data shall update and reg_wr_en shall pulse for exactly one cycle in the same cycle.
REQ-024 A write to address >= NUM_REGS, or any frame with cmd[6]=1, shall produce no reg_wr_en and shall pulse frame_err when the frame completes.
REQ-025 SS_n rising before 40 bits shall pulse frame_err, produce no write, and return to IDLE.
REQ-026 Rising edges after the 40th (WAIT_SS) shall be ignored; no second write and no error.
REQ-027 An SCLK edge in the same cycle as the SS_n rising edge shall be ignored; SS_n takes priority.
REQ-028 reg_wr_addr, reg_wr_data and reg_rd_addr shall hold their last values between frames.

Reset
REQ-029 Reset shall force IDLE, the counter to 0, the shift registers to 0, all outputs to 0, and the synchronizers to idle levels (SCLK 0, MOSI 0, SS_n 1).
REQ-030 After reset release while SS_n is low, the block shall stay in IDLE until a new SS_n falling edge occurs; a partial frame is discarded silently with no frame_err.

Verification
REQ-031 Write cmd 0x05, data 0xDEADBEEF -> single reg_wr_en pulse, addr 5, data 0xDEADBEEF, frame_err 0.
REQ-032 Read cmd 0x83 with bank[3]=0x12345678 -> reg_rd_addr 3; MISO bits 8..39 equal 0x12345678 MSB first; MISO 0 during bits 0..7.
REQ-033 Write cmd 0x3F (63 >= 60) -> no reg_wr_en, one frame_err pulse; read cmd 0xBC -> MISO data 0x00000000.
REQ-034 SS_n deasserted after 20 bits of a write -> frame_err pulse, no reg_wr_en, state IDLE; the next full frame is accepted normally.
REQ-035 45 SCLK pulses on write cmd 0x01 -> exactly one reg_wr_en pulse at bit 40; extra bits ignored.
REQ-036 reset_reset_n asserted at bit 12 of a write, released with SS_n low -> outputs 0, no write, no frame_err until the next SS_n falling edge.
